// File: rtl/demux32_deserializer.sv
// Registered 1:32 demultiplexer/deserializer: rebuilds a 32-bit word from a serial
// bit stream, either by direct bit-addressed writes or by an auto-incrementing capture.
module demux32_deserializer #(
  parameter int WIDTH        = 32,
  parameter bit CLR_ON_START = 1'b1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             XEN,
  input  logic [4:0]       XS,
  input  logic             XIN,
  input  logic             XWR,
  input  logic             XSTART,
  input  logic             XVALID,
  output logic [WIDTH-1:0] XOUT,
  output logic             XBUSY,
  output logic             XDONE,
  output logic [5:0]       XCNT
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] w_nextWord;
  logic [4:0]       r_ptr;
  logic [4:0]       w_nextPtr;
  logic [5:0]       r_cnt;
  logic [5:0]       w_nextCnt;
  logic             r_busy;
  logic             r_done;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state <= IDLE;
      r_word  <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_word  <= w_nextWord;
      r_ptr   <= w_nextPtr;
      r_cnt   <= w_nextCnt;
      r_busy  <= (w_nextState == CAPTURE);
      r_done  <= (w_nextState == DONE);
    end
  end

  // XSTART has priority over XWR in IDLE; a stalled capture holds everything.
  always_comb begin
    w_nextState = r_state;
    w_nextWord  = r_word;
    w_nextPtr   = r_ptr;
    w_nextCnt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (XEN) begin
          if (XSTART) begin
            w_nextState = CAPTURE;
            w_nextPtr   = XS;
            w_nextCnt   = '0;
            if (CLR_ON_START) begin
              w_nextWord = '0;
            end
          end else if (XWR) begin
            w_nextWord[XS] = XIN;
          end
        end
      end
      CAPTURE: begin
        if (XEN && XVALID) begin
          w_nextWord[r_ptr] = XIN;
          w_nextPtr         = r_ptr + 5'd1;
          w_nextCnt         = r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            w_nextState = DONE;
          end
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign XOUT  = XEN ? r_word : '0;
  assign XBUSY = r_busy;
  assign XDONE = r_done;
  assign XCNT  = r_cnt;

endmodule
